modem_host_ctrl: RTL and testbench

Host-side SPI master and command sequencer for the beta modem's register/RAM SPI slave. It turns single register/RAM accesses and a "launch message" command from local host logic into 24-bit SPI frames. For launch, it programs the message length, sets the transmit bit, and polls until the modem clears it. It sits in the host FPGA/test harness, at the opposite end of the modem's SPI link.

---
 rtl/modem_spi_pkg.sv | 47 ++++
 rtl/modem_spi_master.sv | 80 ++++++++
 rtl/modem_host_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_modem_host_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/modem_spi_pkg.sv
// Shared constants, types and frame helper for the modem SPI host controller.
package modem_spi_pkg;

   localparam int FRAME_BITS = 24;
   localparam int RAM_DEPTH  = 1000;

   // Modem register map
   localparam logic [9:0] REG_LEN_HI = 10'd1000;
   localparam logic [9:0] REG_LEN_LO = 10'd1001;
   localparam logic [9:0] REG_SPEED  = 10'd1018;
   localparam logic [9:0] REG_CW     = 10'd1019;
   localparam logic [9:0] REG_ID0    = 10'd1020;
   localparam logic [9:0] REG_ID1    = 10'd1021;
   localparam logic [9:0] REG_ID2    = 10'd1022;
   localparam logic [9:0] REG_CTRL   = 10'd1023;

   typedef enum logic [1:0] {
      OP_READ   = 2'b00,
      OP_WRITE  = 2'b01,
      OP_LAUNCH = 2'b10,
      OP_RSVD   = 2'b11
   } cmd_op_e;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_CHECK     = 3'd1,
      ST_XFER      = 3'd2,
      ST_GAP       = 3'd3,
      ST_POLL_WAIT = 3'd4,
      ST_RESP      = 3'd5
   } ctrl_state_e;

   typedef enum logic [1:0] {
      STEP_LEN_HI = 2'd0,
      STEP_LEN_LO = 2'd1,
      STEP_GO     = 2'd2,
      STEP_POLL   = 2'd3
   } launch_step_e;

   // Frame layout: {rw, 5'b0, addr[9:0]} header then data byte (0x00 on reads).
   function automatic logic [FRAME_BITS-1:0] make_frame(input logic       wr,
                                                        input logic [9:0] addr,
                                                        input logic [7:0] data);
      return {wr, 5'b0, addr, (wr ? data : 8'h00)};
   endfunction

endpackage

// File: rtl/modem_spi_master.sv
// Single 24-bit mode-0 SPI frame engine. Counts half-periods from the ssn fall:
// half 1..48 toggle sclk (odd = rising, even = falling), half 49 raises ssn,
// halves 50..52 are the inter-frame gap; done pulses on the last gap tick.
// A start presented with done restarts immediately, keeping frames back to back.
module modem_spi_master
   import modem_spi_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [FRAME_BITS-1:0] tx_word,
   output logic                  done,
   output logic [7:0]            rx_byte,
   output logic                  sclk,
   output logic                  ssn,
   output logic                  mosi,
   input  logic                  miso
);

   localparam int         DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [5:0] HALF_LAST = 6'd51;

   logic                  active;
   logic [DIV_W-1:0]      div_cnt;
   logic [5:0]            half_cnt;
   logic [5:0]            half_nxt;
   logic [FRAME_BITS-1:0] shreg;
   logic                  tick;

   assign tick     = active && (div_cnt == DIV_W'(CLK_DIV - 1));
   assign half_nxt = half_cnt + 6'd1;
   assign done     = tick && (half_cnt == HALF_LAST);

   // Frame sequencing: divider, half-period counter, shifting and pin drive.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         active   <= 1'b0;
         div_cnt  <= '0;
         half_cnt <= '0;
         shreg    <= '0;
         rx_byte  <= '0;
         sclk     <= 1'b0;
         ssn      <= 1'b1;
         mosi     <= 1'b0;
      end else if (start && (!active || done)) begin
         active   <= 1'b1;
         div_cnt  <= '0;
         half_cnt <= '0;
         shreg    <= tx_word;
         rx_byte  <= '0;
         sclk     <= 1'b0;
         ssn      <= 1'b0;
         mosi     <= tx_word[FRAME_BITS-1];
      end else if (tick) begin
         div_cnt  <= '0;
         half_cnt <= half_nxt;
         if (half_nxt <= 6'd48) begin
            if (half_nxt[0]) begin
               sclk <= 1'b1;
               // rising edges 17..24 carry the read byte
               if (half_nxt >= 6'd33) rx_byte <= {rx_byte[6:0], miso};
            end else begin
               sclk  <= 1'b0;
               shreg <= {shreg[FRAME_BITS-2:0], 1'b0};
               mosi  <= (half_nxt == 6'd48) ? 1'b0 : shreg[FRAME_BITS-2];
            end
         end
         if (half_nxt == 6'd49) ssn <= 1'b1;
         if (done) begin
            active   <= 1'b0;
            half_cnt <= '0;
         end
      end else if (active) begin
         div_cnt <= div_cnt + DIV_W'(1);
      end
   end

endmodule

// File: rtl/modem_host_ctrl.sv
// Host-side command sequencer for the modem SPI slave: single register/RAM
// accesses plus a launch command that programs the length, sets transmit and
// polls the control register until the modem clears it.
//
// Command handshake: a command is taken on a clock edge where i_cmd_valid and
// o_cmd_ready are both high; o_cmd_ready stays low from accept until RESP
// exits, and o_rsp_valid is a single-cycle strobe with no back-pressure.
module modem_host_ctrl
   import modem_spi_pkg::*;
#(
   parameter int CLK_DIV  = 4,
   parameter int POLL_GAP = 64,
   parameter int POLL_MAX = 1024
) (
   input  logic       clk,
   input  logic       reset,
   output logic       o_sclk,
   output logic       o_ssn,
   output logic       o_mosi,
   input  logic       i_miso,
   input  logic       i_cmd_valid,
   output logic       o_cmd_ready,
   input  logic [1:0] i_cmd_op,
   input  logic [9:0] i_cmd_addr,
   input  logic [7:0] i_cmd_data,
   input  logic [9:0] i_cmd_len,
   output logic       o_rsp_valid,
   output logic [7:0] o_rsp_data,
   output logic       o_rsp_err,
   output logic       o_busy,
   output logic [2:0] o_dbg_state
);

   localparam logic [15:0] GAP_LAST = 16'(POLL_GAP - 1);
   localparam logic [10:0] POLL_LIM = 11'(POLL_MAX);

   ctrl_state_e     state;
   launch_step_e    step;
   launch_step_e    frame_step;
   logic [1:0]      cmd_op;
   logic [9:0]      cmd_addr;
   logic [7:0]      cmd_data;
   logic [9:0]      cmd_len;
   logic [10:0]     poll_cnt;
   logic [15:0]     gap_cnt;

   logic            is_launch;
   logic            is_rw;
   logic            len_ok;
   logic            spi_start;
   logic            spi_done;
   logic [7:0]      spi_rx;
   logic            frame_wr;
   logic [9:0]      frame_addr;
   logic [7:0]      frame_data;
   logic [FRAME_BITS-1:0] tx_word;

   assign is_launch   = (cmd_op == OP_LAUNCH);
   assign is_rw       = (cmd_op == OP_READ) || (cmd_op == OP_WRITE);
   assign len_ok      = (cmd_len != 10'd0) && (cmd_len <= 10'(RAM_DEPTH));
   assign o_dbg_state = state;

   // Which launch frame is being started this cycle.
   always_comb begin
      frame_step = STEP_POLL;
      if (state == ST_CHECK)     frame_step = STEP_LEN_HI;
      else if (state == ST_XFER) frame_step = launch_step_e'(step + 2'd1);
   end

   // Frame contents for the access or launch step being started.
   always_comb begin
      frame_wr   = (cmd_op == OP_WRITE);
      frame_addr = cmd_addr;
      frame_data = cmd_data;
      if (is_launch) begin
         case (frame_step)
            STEP_LEN_HI: begin
               frame_wr   = 1'b1;
               frame_addr = REG_LEN_HI;
               frame_data = {6'b0, cmd_len[9:8]};
            end
            STEP_LEN_LO: begin
               frame_wr   = 1'b1;
               frame_addr = REG_LEN_LO;
               frame_data = cmd_len[7:0];
            end
            STEP_GO: begin
               frame_wr   = 1'b1;
               frame_addr = REG_CTRL;
               frame_data = 8'h01;
            end
            default: begin
               frame_wr   = 1'b0;
               frame_addr = REG_CTRL;
               frame_data = 8'h00;
            end
         endcase
      end
      tx_word = make_frame(frame_wr, frame_addr, frame_data);
   end

   // Frame start requests: first frame from CHECK, launch set-up frames chained
   // on done, polls when the inter-poll wait expires.
   always_comb begin
      spi_start = 1'b0;
      case (state)
         ST_CHECK:              spi_start = is_rw || (is_launch && len_ok);
         ST_XFER:               spi_start = spi_done && is_launch &&
                                            ((step == STEP_LEN_HI) || (step == STEP_LEN_LO));
         ST_GAP, ST_POLL_WAIT:  spi_start = (gap_cnt == GAP_LAST);
         default:               spi_start = 1'b0;
      endcase
   end

   modem_spi_master #(.CLK_DIV(CLK_DIV)) u_spi (
      .clk     (clk),
      .reset   (reset),
      .start   (spi_start),
      .tx_word (tx_word),
      .done    (spi_done),
      .rx_byte (spi_rx),
      .sclk    (o_sclk),
      .ssn     (o_ssn),
      .mosi    (o_mosi),
      .miso    (i_miso)
   );

   // Command sequencer FSM with registered handshake and response outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= ST_IDLE;
         step        <= STEP_LEN_HI;
         cmd_op      <= 2'b00;
         cmd_addr    <= '0;
         cmd_data    <= '0;
         cmd_len     <= '0;
         poll_cnt    <= '0;
         gap_cnt     <= '0;
         o_cmd_ready <= 1'b1;
         o_rsp_valid <= 1'b0;
         o_rsp_data  <= '0;
         o_rsp_err   <= 1'b0;
         o_busy      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (i_cmd_valid && o_cmd_ready) begin
                  cmd_op      <= i_cmd_op;
                  cmd_addr    <= i_cmd_addr;
                  cmd_data    <= i_cmd_data;
                  cmd_len     <= i_cmd_len;
                  step        <= STEP_LEN_HI;
                  poll_cnt    <= '0;
                  o_cmd_ready <= 1'b0;
                  o_busy      <= 1'b1;
                  state       <= ST_CHECK;
               end
            end
            ST_CHECK: begin
               if (spi_start) begin
                  state <= ST_XFER;
               end else begin
                  // reserved op or out-of-range launch length
                  o_rsp_valid <= 1'b1;
                  o_rsp_err   <= 1'b1;
                  o_rsp_data  <= 8'h00;
                  state       <= ST_RESP;
               end
            end
            ST_XFER: begin
               if (spi_done) begin
                  if (!is_launch) begin
                     o_rsp_valid <= 1'b1;
                     o_rsp_err   <= 1'b0;
                     o_rsp_data  <= (cmd_op == OP_READ) ? spi_rx : 8'h00;
                     state       <= ST_RESP;
                  end else begin
                     case (step)
                        STEP_LEN_HI, STEP_LEN_LO: begin
                           step <= launch_step_e'(step + 2'd1);
                        end
                        STEP_GO: begin
                           step    <= STEP_POLL;
                           gap_cnt <= '0;
                           state   <= ST_GAP;
                        end
                        default: begin
                           if (!spi_rx[0] || (poll_cnt == POLL_LIM)) begin
                              o_rsp_valid <= 1'b1;
                              o_rsp_err   <= spi_rx[0];
                              o_rsp_data  <= spi_rx;
                              state       <= ST_RESP;
                           end else begin
                              gap_cnt <= '0;
                              state   <= ST_POLL_WAIT;
                           end
                        end
                     endcase
                  end
               end
            end
            ST_GAP, ST_POLL_WAIT: begin
               if (spi_start) begin
                  state    <= ST_XFER;
                  poll_cnt <= (poll_cnt == POLL_LIM) ? poll_cnt : poll_cnt + 11'd1;
               end else begin
                  gap_cnt <= gap_cnt + 16'd1;
               end
            end
            ST_RESP: begin
               o_rsp_valid <= 1'b0;
               o_busy      <= 1'b0;
               o_cmd_ready <= 1'b1;
               state       <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_modem_host_ctrl.sv
// Directed bench for modem_host_ctrl with a behavioural modem SPI slave.
module tb_modem_host_ctrl;
   import modem_spi_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic       o_sclk, o_ssn, o_mosi;
   logic       i_miso = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       o_cmd_ready;
   logic [1:0] cmd_op = 2'b00;
   logic [9:0] cmd_addr = '0;
   logic [7:0] cmd_data = '0;
   logic [9:0] cmd_len = '0;
   logic       o_rsp_valid;
   logic [7:0] o_rsp_data;
   logic       o_rsp_err;
   logic       o_busy;
   logic [2:0] o_dbg_state;

   int total = 0;
   int bad   = 0;

   modem_host_ctrl #(.CLK_DIV(4), .POLL_GAP(64), .POLL_MAX(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .o_sclk      (o_sclk),
      .o_ssn       (o_ssn),
      .o_mosi      (o_mosi),
      .i_miso      (i_miso),
      .i_cmd_valid (cmd_valid),
      .o_cmd_ready (o_cmd_ready),
      .i_cmd_op    (cmd_op),
      .i_cmd_addr  (cmd_addr),
      .i_cmd_data  (cmd_data),
      .i_cmd_len   (cmd_len),
      .o_rsp_valid (o_rsp_valid),
      .o_rsp_data  (o_rsp_data),
      .o_rsp_err   (o_rsp_err),
      .o_busy      (o_busy),
      .o_dbg_state (o_dbg_state)
   );

   // ---------------- modem slave model ----------------
   logic [7:0]  mem [0:1023];
   logic        ctrl_tx = 1'b0;
   logic [3:0]  gpio = 4'h0;
   int          clear_after = 0;
   int          slv_polls = 0;
   int          slv_bits = 0;
   int          partial = 0;
   int          ssn_falls = 0;
   logic [23:0] slv_sh = '0;
   logic [7:0]  rd_byte = '0;
   logic        prev_ssn = 1'b1;
   logic        prev_sclk = 1'b0;
   logic [23:0] frame_q[$];
   logic [23:0] exp_q[$];

   always @(o_ssn or o_sclk) begin
      if (prev_ssn === 1'b1 && o_ssn === 1'b0) begin
         ssn_falls++;
         slv_bits = 0;
         slv_sh   = '0;
         i_miso   = 1'b0;
      end else if (prev_ssn === 1'b0 && o_ssn === 1'b1) begin
         if (slv_bits == 24) begin
            frame_q.push_back(slv_sh);
            if (slv_sh[23]) begin
               if (slv_sh[17:8] == 10'd1023) begin
                  ctrl_tx   = slv_sh[0];
                  slv_polls = 0;
               end else begin
                  mem[slv_sh[17:8]] = slv_sh[7:0];
               end
            end
         end else begin
            partial++;
         end
         i_miso = 1'b0;
      end else if (o_ssn === 1'b0 && prev_sclk === 1'b0 && o_sclk === 1'b1) begin
         slv_sh = {slv_sh[22:0], o_mosi};
         slv_bits++;
      end else if (o_ssn === 1'b0 && prev_sclk === 1'b1 && o_sclk === 1'b0) begin
         if (slv_bits == 16) begin
            rd_byte = 8'h00;
            if (!slv_sh[15]) begin
               if (slv_sh[9:0] == 10'd1023) begin
                  slv_polls++;
                  if (clear_after != 0 && slv_polls >= clear_after) ctrl_tx = 1'b0;
                  rd_byte = {3'b000, gpio, ctrl_tx};
               end else if (slv_sh[9:0] == 10'd1020) begin
                  rd_byte = 8'h96;
               end else begin
                  rd_byte = mem[slv_sh[9:0]];
               end
            end
         end
         if (slv_bits >= 16 && slv_bits <= 23) i_miso = rd_byte[23 - slv_bits];
      end
      prev_ssn  = o_ssn;
      prev_sclk = o_sclk;
   end

   // ---------------- driver tasks ----------------
   task automatic issue(input logic [1:0] op, input logic [9:0] addr,
                        input logic [7:0] data, input logic [9:0] len);
      int n = 0;
      @(negedge clk);
      while (!o_cmd_ready && n < 3000) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (o_cmd_ready !== 1'b1) begin
         bad++;
         $display("FAIL issue_ready got=%b want=1", o_cmd_ready);
      end
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_addr  = addr;
      cmd_data  = data;
      cmd_len   = len;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(output int lat, output logic seen);
      lat  = 0;
      seen = 1'b0;
      while (!seen && lat < 5000) begin
         @(posedge clk);
         #1;
         lat++;
         if (o_rsp_valid === 1'b1) seen = 1'b1;
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      total++; if (o_ssn !== 1'b1)       begin bad++; $display("FAIL reset_ssn got=%b want=1", o_ssn); end
      total++; if (o_sclk !== 1'b0)      begin bad++; $display("FAIL reset_sclk got=%b want=0", o_sclk); end
      total++; if (o_mosi !== 1'b0)      begin bad++; $display("FAIL reset_mosi got=%b want=0", o_mosi); end
      total++; if (o_cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", o_cmd_ready); end
      total++; if (o_rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b want=0", o_rsp_valid); end
      total++; if (o_rsp_data !== 8'h00) begin bad++; $display("FAIL reset_rsp_data got=%h want=00", o_rsp_data); end
      total++; if (o_rsp_err !== 1'b0)   begin bad++; $display("FAIL reset_rsp_err got=%b want=0", o_rsp_err); end
      total++; if (o_busy !== 1'b0)      begin bad++; $display("FAIL reset_busy got=%b want=0", o_busy); end
      total++; if (o_dbg_state !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", o_dbg_state); end
   endtask

   task automatic test_write();
      int lat;
      logic seen;
      int base = frame_q.size();
      issue(2'b01, 10'd17, 8'h5A, 10'd0);
      total++; if (o_busy !== 1'b1 || o_cmd_ready !== 1'b0) begin
         bad++; $display("FAIL write_busy got busy=%b ready=%b want busy=1 ready=0", o_busy, o_cmd_ready);
      end
      wait_rsp(lat, seen);
      total++; if (lat != 209) begin bad++; $display("FAIL write_latency got=%0d want=209", lat); end
      total++; if (o_rsp_err !== 1'b0 || o_rsp_data !== 8'h00) begin
         bad++; $display("FAIL write_rsp got err=%b data=%h want err=0 data=00", o_rsp_err, o_rsp_data);
      end
      @(posedge clk);
      #1;
      total++; if (o_rsp_valid !== 1'b0 || o_busy !== 1'b0 || o_cmd_ready !== 1'b1) begin
         bad++; $display("FAIL write_release got valid=%b busy=%b ready=%b want 0 0 1", o_rsp_valid, o_busy, o_cmd_ready);
      end
      exp_q.push_back(24'h80115A);
      total++; if (frame_q.size() != base + 1) begin
         bad++; $display("FAIL write_frame_count got=%0d want=%0d", frame_q.size() - base, 1);
      end
      while (exp_q.size() > 0) begin
         logic [23:0] e = exp_q.pop_front();
         total++; if (frame_q.size() <= base || frame_q[base] !== e) begin
            bad++; $display("FAIL write_frame got=%h want=%h", (frame_q.size() > base) ? frame_q[base] : 24'hxxxxxx, e);
         end
      end
   endtask

   task automatic test_read();
      int lat;
      logic seen;
      int base = frame_q.size();
      issue(2'b00, 10'd1020, 8'h00, 10'd0);
      wait_rsp(lat, seen);
      total++; if (lat != 209) begin bad++; $display("FAIL read_latency got=%0d want=209", lat); end
      total++; if (o_rsp_data !== 8'h96 || o_rsp_err !== 1'b0) begin
         bad++; $display("FAIL read_rsp got err=%b data=%h want err=0 data=96", o_rsp_err, o_rsp_data);
      end
      @(negedge clk);
      total++; if (frame_q.size() != base + 1 || frame_q[base] !== 24'h03FC00) begin
         bad++; $display("FAIL read_frame got n=%0d frame=%h want n=1 frame=03fc00", frame_q.size() - base,
                         (frame_q.size() > base) ? frame_q[base] : 24'h0);
      end
   endtask

   task automatic test_reserved();
      int lat;
      logic seen;
      int falls = ssn_falls;
      issue(2'b11, 10'd5, 8'h00, 10'd0);
      wait_rsp(lat, seen);
      total++; if (lat != 1 || o_rsp_err !== 1'b1 || o_rsp_data !== 8'h00) begin
         bad++; $display("FAIL reserved_rsp got lat=%0d err=%b data=%h want lat=1 err=1 data=00", lat, o_rsp_err, o_rsp_data);
      end
      repeat (4) @(negedge clk);
      total++; if (ssn_falls != falls) begin bad++; $display("FAIL reserved_spi got falls=%0d want=%0d", ssn_falls, falls); end
   endtask

   task automatic test_bad_len();
      int lat;
      logic seen;
      int falls = ssn_falls;
      issue(2'b10, 10'd0, 8'h00, 10'd0);
      wait_rsp(lat, seen);
      total++; if (lat != 1 || o_rsp_err !== 1'b1 || o_rsp_data !== 8'h00) begin
         bad++; $display("FAIL len0_rsp got lat=%0d err=%b data=%h want lat=1 err=1 data=00", lat, o_rsp_err, o_rsp_data);
      end
      issue(2'b10, 10'd0, 8'h00, 10'd1001);
      wait_rsp(lat, seen);
      total++; if (lat != 1 || o_rsp_err !== 1'b1 || o_rsp_data !== 8'h00) begin
         bad++; $display("FAIL len1001_rsp got lat=%0d err=%b data=%h want lat=1 err=1 data=00", lat, o_rsp_err, o_rsp_data);
      end
      repeat (4) @(negedge clk);
      total++; if (ssn_falls != falls) begin bad++; $display("FAIL bad_len_spi got falls=%0d want=%0d", ssn_falls, falls); end
   endtask

   task automatic test_launch();
      int lat;
      logic seen;
      int base = frame_q.size();
      gpio        = 4'b0101;
      clear_after = 3;
      issue(2'b10, 10'd0, 8'h00, 10'd300);
      wait_rsp(lat, seen);
      // 4 frames + gap + 1 for the first poll, then 2 x (gap + frame)
      total++; if (lat != 1441) begin bad++; $display("FAIL launch_latency got=%0d want=1441", lat); end
      total++; if (o_rsp_err !== 1'b0 || o_rsp_data !== 8'h0A) begin
         bad++; $display("FAIL launch_rsp got err=%b data=%h want err=0 data=0a", o_rsp_err, o_rsp_data);
      end
      @(negedge clk);
      exp_q.push_back(24'h83E801);
      exp_q.push_back(24'h83E92C);
      exp_q.push_back(24'h83FF01);
      for (int i = 0; i < 3; i++) exp_q.push_back(24'h03FF00);
      total++; if (frame_q.size() != base + 6) begin
         bad++; $display("FAIL launch_frame_count got=%0d want=6", frame_q.size() - base);
      end
      for (int i = 0; exp_q.size() > 0; i++) begin
         logic [23:0] e = exp_q.pop_front();
         logic [23:0] g = (frame_q.size() > base + i) ? frame_q[base + i] : 24'h0;
         total++; if (g !== e) begin bad++; $display("FAIL launch_frame%0d got=%h want=%h", i, g, e); end
      end
   endtask

   task automatic test_timeout();
      int lat;
      logic seen;
      int base = frame_q.size();
      gpio        = 4'b0000;
      clear_after = 0;
      issue(2'b10, 10'd0, 8'h00, 10'd1000);
      wait_rsp(lat, seen);
      total++; if (lat != 1713) begin bad++; $display("FAIL timeout_latency got=%0d want=1713", lat); end
      total++; if (o_rsp_err !== 1'b1 || o_rsp_data !== 8'h01) begin
         bad++; $display("FAIL timeout_rsp got err=%b data=%h want err=1 data=01", o_rsp_err, o_rsp_data);
      end
      @(negedge clk);
      total++; if (slv_polls != 4) begin bad++; $display("FAIL timeout_polls got=%0d want=4", slv_polls); end
      exp_q.push_back(24'h83E803);
      exp_q.push_back(24'h83E9E8);
      exp_q.push_back(24'h83FF01);
      for (int i = 0; i < 4; i++) exp_q.push_back(24'h03FF00);
      total++; if (frame_q.size() != base + 7) begin
         bad++; $display("FAIL timeout_frame_count got=%0d want=7", frame_q.size() - base);
      end
      for (int i = 0; exp_q.size() > 0; i++) begin
         logic [23:0] e = exp_q.pop_front();
         logic [23:0] g = (frame_q.size() > base + i) ? frame_q[base + i] : 24'h0;
         total++; if (g !== e) begin bad++; $display("FAIL timeout_frame%0d got=%h want=%h", i, g, e); end
      end
   endtask

   task automatic test_reset_midframe();
      int lat;
      logic seen;
      int n = 0;
      int base = frame_q.size();
      int pbase = partial;
      logic stray = 1'b0;
      issue(2'b00, 10'd1020, 8'h00, 10'd0);
      while (o_ssn !== 1'b0 && n < 100) begin @(posedge clk); n++; end
      n = 0;
      while (slv_bits < 10 && n < 500) begin @(posedge clk); n++; end
      total++; if (slv_bits != 10) begin bad++; $display("FAIL midframe_reach got bits=%0d want=10", slv_bits); end
      @(negedge clk);
      reset = 1'b1;
      #1;
      total++; if (o_ssn !== 1'b1 || o_sclk !== 1'b0) begin
         bad++; $display("FAIL midframe_pins got ssn=%b sclk=%b want ssn=1 sclk=0", o_ssn, o_sclk);
      end
      repeat (3) begin
         @(negedge clk);
         if (o_rsp_valid !== 1'b0) stray = 1'b1;
      end
      reset = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (o_rsp_valid !== 1'b0) stray = 1'b1;
      end
      total++; if (stray !== 1'b0) begin bad++; $display("FAIL midframe_no_rsp got stray=%b want=0", stray); end
      total++; if (partial != pbase + 1 || frame_q.size() != base) begin
         bad++; $display("FAIL midframe_discard got partial=%0d frames=%0d want partial=1 frames=0",
                         partial - pbase, frame_q.size() - base);
      end
      issue(2'b00, 10'd1020, 8'h00, 10'd0);
      wait_rsp(lat, seen);
      total++; if (lat != 209 || o_rsp_data !== 8'h96 || o_rsp_err !== 1'b0) begin
         bad++; $display("FAIL midframe_reread got lat=%0d data=%h err=%b want lat=209 data=96 err=0", lat, o_rsp_data, o_rsp_err);
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_reserved();
      test_bad_len();
      test_launch();
      test_timeout();
      test_reset_midframe();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
